prbs4_checker: RTL and testbench

Serial checker for the 4-bit maximal-length PRBS (x^4+x^3+1, period 15) produced by the team's 4-bit LFSR generator. It self-synchronises a local LFSR to the incoming bit stream, declares lock after a run of correct predictions, then counts bit errors against its free-running prediction. It drops lock when errors become excessive. It sits on the receive side of a loopback or GPIO link and provides lock and error status to LEDs or debug logic.

---
 rtl/prbs4_checker_if.sv | 21 ++
 rtl/prbs4_checker.sv | 119 +++++++++++
 tb/tb_prbs4_checker.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/prbs4_checker_if.sv
// Serial PRBS4 receive link: bit stream in, lock and error status out.
interface prbs4_checker_if #(
  parameter int ERR_W = 16
);
  logic             bit_i;
  logic             bit_valid_i;
  logic             clr_cnt_i;
  logic             locked_o;
  logic             err_pulse_o;
  logic [ERR_W-1:0] err_count_o;

  modport master (
    output bit_i, bit_valid_i, clr_cnt_i,
    input  locked_o, err_pulse_o, err_count_o
  );

  modport slave (
    input  bit_i, bit_valid_i, clr_cnt_i,
    output locked_o, err_pulse_o, err_count_o
  );
endinterface

// File: rtl/prbs4_checker.sv
// Self-synchronising checker for the x^4+x^3+1 PRBS: locks onto the stream,
// then counts bit errors against a free-running local LFSR.
module prbs4_checker #(
  parameter int LOCK_COUNT = 15,
  parameter int LOSS_ERRS  = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  prbs4_checker_if.slave   bus
);
  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [7:0] LOCK_C = 8'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_ERRS);

  state_t           state_q, state_d;
  logic [3:0]       h_q, h_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [3:0]       wbit_q, wbit_d;
  logic [3:0]       werr_q, werr_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic             pred;
  logic             miss;
  logic [3:0]       werr_inc;
  logic [7:0]       match_inc;
  logic [ERR_W-1:0] cnt_base;

  assign pred      = h_q[3] ^ h_q[2];
  assign miss      = bus.bit_valid_i && (state_q == LOCKED) && (bus.bit_i != pred);
  assign werr_inc  = werr_q + {3'b000, miss};
  assign match_inc = match_q + 8'd1;
  // Clear first, then count, so a clear coinciding with an error leaves 1.
  assign cnt_base  = bus.clr_cnt_i ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    fill_d  = fill_q;
    match_d = match_q;
    wbit_d  = wbit_q;
    werr_d  = werr_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_base;
    if (miss && !(&cnt_base)) begin
      cnt_d = cnt_base + ERR_W'(1);
    end
    if (bus.bit_valid_i) begin
      if (state_q == SEARCH) begin
        h_d = {h_q[2:0], bus.bit_i};
        if (fill_q != 3'd4) begin
          fill_d = fill_q + 3'd1;
        end else if ((bus.bit_i == pred) && (h_q != 4'd0)) begin
          if (match_inc == LOCK_C) begin
            state_d = LOCKED;
            match_d = 8'd0;
            fill_d  = 3'd0;
            wbit_d  = 4'd0;
            werr_d  = 4'd0;
          end else begin
            match_d = match_inc;
          end
        end else begin
          match_d = 8'd0;
        end
      end else begin
        // Free-run on our own prediction so a single flipped bit costs one error.
        h_d     = {h_q[2:0], pred};
        pulse_d = miss;
        if (miss && (werr_inc == LOSS_C)) begin
          state_d = SEARCH;
          fill_d  = 3'd0;
          match_d = 8'd0;
          wbit_d  = 4'd0;
          werr_d  = 4'd0;
        end else if (wbit_q == 4'd14) begin
          wbit_d = 4'd0;
          werr_d = 4'd0;
        end else begin
          wbit_d = wbit_q + 4'd1;
          werr_d = werr_inc;
        end
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      h_q      <= 4'd0;
      fill_q   <= 3'd0;
      match_q  <= 8'd0;
      wbit_q   <= 4'd0;
      werr_q   <= 4'd0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      wbit_q   <= wbit_d;
      werr_q   <= werr_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.locked_o    = locked_q;
  assign bus.err_pulse_o = pulse_q;
  assign bus.err_count_o = cnt_q;
endmodule

// File: tb/tb_prbs4_checker.sv
// Bench for prbs4_checker: cycle scoreboard against a reference model plus
// directed checks of lock timing, loss of lock, clearing and saturation.
module tb_prbs4_checker;
  localparam int LOCK_COUNT = 15;
  localparam int LOSS_ERRS  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prbs4_checker_if #(.ERR_W(16)) bus ();
  prbs4_checker_if #(.ERR_W(4))  bus4 ();

  assign bus4.bit_i       = bus.bit_i;
  assign bus4.bit_valid_i = bus.bit_valid_i;
  assign bus4.clr_cnt_i   = bus.clr_cnt_i;

  prbs4_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_ERRS(LOSS_ERRS), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  prbs4_checker #(.LOCK_COUNT(LOCK_COUNT), .LOSS_ERRS(LOSS_ERRS), .ERR_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int tot = 0;
  int bad = 0;
  int pulse_seen = 0;
  int lock_cycles = 0;
  logic [31:0] sb[$];
  logic [3:0] g;

  // reference model state
  logic       m_lock, m_pulse;
  logic [3:0] m_h;
  int         m_fill, m_match, m_wbit, m_werr, m_cnt, m_cnt4;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tot++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic b, input logic v, input logic c);
    logic p;
    logic hz;
    if (r) begin
      m_lock = 0; m_pulse = 0; m_cnt = 0; m_cnt4 = 0; m_h = 4'd0;
      m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0;
      return;
    end
    m_pulse = 0;
    if (c) begin m_cnt = 0; m_cnt4 = 0; end
    if (!v) return;
    p  = m_h[3] ^ m_h[2];
    hz = (m_h == 4'd0);
    if (!m_lock) begin
      m_h = {m_h[2:0], b};
      if (m_fill < 4) m_fill++;
      else if (b == p && !hz) begin
        m_match++;
        if (m_match == LOCK_COUNT) begin
          m_lock = 1; m_match = 0; m_fill = 0; m_wbit = 0; m_werr = 0;
        end
      end else m_match = 0;
    end else begin
      m_h = {m_h[2:0], p};
      if (b != p) begin
        m_pulse = 1;
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
        m_werr++;
      end
      if (m_werr == LOSS_ERRS) begin
        m_lock = 0; m_fill = 0; m_match = 0; m_wbit = 0; m_werr = 0;
      end else if (m_wbit == 14) begin
        m_wbit = 0; m_werr = 0;
      end else m_wbit++;
    end
  endtask

  task automatic step(input logic r, input logic b, input logic v, input logic c);
    logic [31:0] e;
    logic [31:0] o;
    logic [15:0] ec;
    logic [3:0]  ec4;
    rst = r;
    bus.bit_i = b; bus.bit_valid_i = v; bus.clr_cnt_i = c;
    model_step(r, b, v, c);
    ec  = m_cnt[15:0];
    ec4 = m_cnt4[3:0];
    sb.push_back({8'd0, m_lock, m_pulse, ec, m_lock, m_pulse, ec4});
    @(posedge clk);
    #1;
    o = {8'd0, bus.locked_o, bus.err_pulse_o, bus.err_count_o,
         bus4.locked_o, bus4.err_pulse_o, bus4.err_count_o};
    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      chk("sb", o, e);
    end
    if (bus.err_pulse_o) pulse_seen++;
    if (bus.locked_o) lock_cycles++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    g = 4'b1111;
  endtask

  task automatic send(input logic inv, input logic c);
    g = {g[2:0], g[3] ^ g[2]};
    step(1'b0, g[0] ^ inv, 1'b1, c);
  endtask

  task automatic wait_lock(input logic sparse, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (sparse) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      send(1'b0, 1'b0);
      n++;
      if (bus.locked_o) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int p0;
    int l0;
    bus.bit_i = 1'b0; bus.bit_valid_i = 1'b0; bus.clr_cnt_i = 1'b0;
    @(negedge clk);

    do_reset();
    $display("txn reset");
    chk("rst_locked", {31'd0, bus.locked_o}, 32'd0);
    chk("rst_count", {16'd0, bus.err_count_o}, 32'd0);

    wait_lock(1'b0, n);
    $display("txn clean lock after %0d bits", n);
    chk("lock_at", n, 19);
    for (int i = n; i < 200; i++) send(1'b0, 1'b0);
    chk("clean_pulses", pulse_seen, 0);
    chk("clean_count", {16'd0, bus.err_count_o}, 32'd0);

    p0 = pulse_seen;
    send(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) send(1'b0, 1'b0);
    $display("txn single error");
    chk("one_pulse", pulse_seen - p0, 1);
    chk("one_count", {16'd0, bus.err_count_o}, 32'd1);
    chk("one_locked", {31'd0, bus.locked_o}, 32'd1);

    do_reset();
    wait_lock(1'b0, n);
    for (int i = 0; i < 7; i++) begin
      send(i % 2 == 0, 1'b0);
      if (i == 4) chk("3err_locked", {31'd0, bus.locked_o}, 32'd1);
    end
    $display("txn four errors in window");
    chk("loss_locked", {31'd0, bus.locked_o}, 32'd0);
    chk("loss_count", {16'd0, bus.err_count_o}, 32'd4);
    wait_lock(1'b0, n);
    chk("relock_at", n, 19);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 30; i++)
      send(i == 2 || i == 5 || i == 8 || i == 16 || i == 19 || i == 22, 1'b0);
    $display("txn 3+3 errors over two windows");
    chk("two_win_locked", {31'd0, bus.locked_o}, 32'd1);
    chk("two_win_count", {16'd0, bus.err_count_o}, 32'd6);

    do_reset();
    l0 = lock_cycles;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    $display("txn constant streams");
    chk("const_lock_cycles", lock_cycles - l0, 0);
    chk("const_count", {16'd0, bus.err_count_o}, 32'd0);

    do_reset();
    wait_lock(1'b1, n);
    $display("txn sparse lock after %0d valid bits", n);
    chk("sparse_lock_at", n, 19);
    send(1'b1, 1'b0);
    chk("pre_rst_count", {16'd0, bus.err_count_o}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_locked", {31'd0, bus.locked_o}, 32'd0);
    chk("rst_mid_count", {16'd0, bus.err_count_o}, 32'd0);

    do_reset();
    wait_lock(1'b0, n);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 15; i++) send(i == 0, 1'b0);
    chk("five_count", {16'd0, bus.err_count_o}, 32'd5);
    send(1'b1, 1'b1);
    $display("txn clear with error");
    chk("clr_err_count", {16'd0, bus.err_count_o}, 32'd1);
    for (int k = 0; k < 20; k++)
      for (int i = 0; i < 15; i++) send(i == 0, 1'b0);
    $display("txn saturation");
    chk("sat_count4", {28'd0, bus4.err_count_o}, 32'd15);
    chk("sat_count16", {16'd0, bus.err_count_o}, 32'd21);
    chk("sat_locked", {30'd0, bus.locked_o, bus4.locked_o}, 32'd3);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
